// File: rtl/mem_access_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : mem_access_sequencer
// Purpose  : Sequences one 1..MAX_BYTES byte read or write burst against a
//            synchronous RAM with RD_LATENCY read latency. Read bytes are
//            assembled little-endian and reported with a one-cycle pulse.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   i_clk            system clock, everything on posedge
//   i_reset          synchronous, active-high reset
//   i_req_valid      request present
//   o_req_ready      idle and able to accept a request
//   i_req_write      1 = write burst, 0 = read burst
//   i_req_len        byte count 0..MAX_BYTES (larger values are clamped)
//   i_req_addr       first byte address
//   i_req_page_wrap  1 = address increments wrap inside the low 8 bits
//   i_req_wdata      write bytes, byte 0 in the LSBs
//   o_rsp_valid      one-cycle completion pulse
//   o_rsp_rdata      read bytes, byte i at [i*DATA_W +: DATA_W]
//   o_mem_address    RAM address
//   o_mem_rden       RAM read enable
//   o_mem_wren       RAM write enable
//   o_mem_wdata      RAM write data
//   i_mem_q          RAM read data
// ============================================================================
module mem_access_sequencer #(
   parameter int ADDR_W     = 16,
   parameter int DATA_W     = 8,
   parameter int MAX_BYTES  = 3,
   parameter int RD_LATENCY = 2
) (
   input  logic                          i_clk,
   input  logic                          i_reset,
   input  logic                          i_req_valid,
   output logic                          o_req_ready,
   input  logic                          i_req_write,
   input  logic [1:0]                    i_req_len,
   input  logic [ADDR_W-1:0]             i_req_addr,
   input  logic                          i_req_page_wrap,
   input  logic [MAX_BYTES*DATA_W-1:0]   i_req_wdata,
   output logic                          o_rsp_valid,
   output logic [MAX_BYTES*DATA_W-1:0]   o_rsp_rdata,
   output logic [ADDR_W-1:0]             o_mem_address,
   output logic                          o_mem_rden,
   output logic                          o_mem_wren,
   output logic [DATA_W-1:0]             o_mem_wdata,
   input  logic [DATA_W-1:0]             i_mem_q
);

   // RD_WAIT lasts RD_LATENCY-1 cycles; the counter runs 0..RD_LATENCY-2.
   localparam int                 c_WAIT_W    = (RD_LATENCY > 2) ? $clog2(RD_LATENCY - 1) : 1;
   localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = c_WAIT_W'((RD_LATENCY >= 2) ? (RD_LATENCY - 2) : 0);
   localparam logic [1:0]         c_MAX_LEN   = 2'(MAX_BYTES);

   typedef enum logic [2:0] {
      S_IDLE       = 3'd0,
      S_RD_ADDR    = 3'd1,
      S_RD_WAIT    = 3'd2,
      S_RD_CAPTURE = 3'd3,
      S_WR         = 3'd4,
      S_DONE       = 3'd5
   } state_t;

   state_t                        r_state;
   logic                          r_req_ready;
   logic                          r_rsp_valid;
   logic [MAX_BYTES*DATA_W-1:0]   r_rsp_rdata;
   logic [ADDR_W-1:0]             r_mem_address;   // doubles as the current byte address
   logic                          r_mem_rden;
   logic                          r_mem_wren;
   logic [DATA_W-1:0]             r_mem_wdata;
   logic [1:0]                    r_len;
   logic [1:0]                    r_idx;
   logic                          r_page_wrap;
   logic [MAX_BYTES*DATA_W-1:0]   r_wdata;
   logic [c_WAIT_W-1:0]           r_wait;

   logic [1:0]                    w_len;
   logic [1:0]                    w_idx_next;
   logic [ADDR_W-1:0]             w_addr_next;
   logic [DATA_W-1:0]             w_wbyte_next;

   assign w_len      = (i_req_len > c_MAX_LEN) ? c_MAX_LEN : i_req_len;
   assign w_idx_next = r_idx + 2'd1;

   // Page-wrap mode keeps the high address bits and rolls only the low byte.
   assign w_addr_next = r_page_wrap ? {r_mem_address[ADDR_W-1:8], r_mem_address[7:0] + 8'd1}
                                    : r_mem_address + ADDR_W'(1);

   always_comb begin
      w_wbyte_next = '0;
      for (int b = 0; b < MAX_BYTES; b++) begin
         if (w_idx_next == 2'(b)) begin
            w_wbyte_next = r_wdata[b*DATA_W +: DATA_W];
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state       <= S_IDLE;
         r_req_ready   <= 1'b1;
         r_rsp_valid   <= 1'b0;
         r_rsp_rdata   <= '0;
         r_mem_address <= '0;
         r_mem_rden    <= 1'b0;
         r_mem_wren    <= 1'b0;
         r_mem_wdata   <= '0;
         r_len         <= '0;
         r_idx         <= '0;
         r_page_wrap   <= 1'b0;
         r_wdata       <= '0;
         r_wait        <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (i_req_valid) begin
                  r_len       <= w_len;
                  r_idx       <= '0;
                  r_page_wrap <= i_req_page_wrap;
                  r_wdata     <= i_req_wdata;
                  r_rsp_rdata <= '0;
                  r_wait      <= '0;
                  r_req_ready <= 1'b0;
                  if (w_len == 2'd0) begin
                     r_state     <= S_DONE;
                     r_rsp_valid <= 1'b1;
                  end else if (i_req_write) begin
                     r_state       <= S_WR;
                     r_mem_wren    <= 1'b1;
                     r_mem_address <= i_req_addr;
                     r_mem_wdata   <= i_req_wdata[DATA_W-1:0];
                  end else begin
                     r_state       <= S_RD_ADDR;
                     r_mem_rden    <= 1'b1;
                     r_mem_address <= i_req_addr;
                  end
               end
            end

            S_RD_ADDR: begin
               if (RD_LATENCY == 1) begin
                  r_state    <= S_RD_CAPTURE;
                  r_mem_rden <= 1'b0;
               end else begin
                  r_state <= S_RD_WAIT;
                  r_wait  <= '0;
               end
            end

            S_RD_WAIT: begin
               if (r_wait == c_WAIT_LAST) begin
                  r_state    <= S_RD_CAPTURE;
                  r_mem_rden <= 1'b0;
               end else begin
                  r_wait <= r_wait + c_WAIT_W'(1);
               end
            end

            S_RD_CAPTURE: begin
               for (int b = 0; b < MAX_BYTES; b++) begin
                  if (r_idx == 2'(b)) begin
                     r_rsp_rdata[b*DATA_W +: DATA_W] <= i_mem_q;
                  end
               end
               r_idx <= w_idx_next;
               if (w_idx_next == r_len) begin
                  r_state       <= S_DONE;
                  r_rsp_valid   <= 1'b1;
                  r_mem_address <= '0;
               end else begin
                  r_state       <= S_RD_ADDR;
                  r_mem_rden    <= 1'b1;
                  r_mem_address <= w_addr_next;
               end
            end

            S_WR: begin
               if (w_idx_next == r_len) begin
                  r_state       <= S_DONE;
                  r_rsp_valid   <= 1'b1;
                  r_mem_wren    <= 1'b0;
                  r_mem_address <= '0;
                  r_mem_wdata   <= '0;
               end else begin
                  r_idx         <= w_idx_next;
                  r_mem_address <= w_addr_next;
                  r_mem_wdata   <= w_wbyte_next;
               end
            end

            S_DONE: begin
               r_state     <= S_IDLE;
               r_rsp_valid <= 1'b0;
               r_req_ready <= 1'b1;
            end

            default: begin
               r_state       <= S_IDLE;
               r_req_ready   <= 1'b1;
               r_rsp_valid   <= 1'b0;
               r_mem_rden    <= 1'b0;
               r_mem_wren    <= 1'b0;
               r_mem_address <= '0;
               r_mem_wdata   <= '0;
            end
         endcase
      end
   end

   assign o_req_ready   = r_req_ready;
   assign o_rsp_valid   = r_rsp_valid;
   assign o_rsp_rdata   = r_rsp_rdata;
   assign o_mem_address = r_mem_address;
   assign o_mem_rden    = r_mem_rden;
   assign o_mem_wren    = r_mem_wren;
   assign o_mem_wdata   = r_mem_wdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_mem_access_sequencer
// Purpose  : Self-checking bench. Three sequencers (RD_LATENCY 2, 1, 4) share
//            one RAM model; a behavioural timing model predicts every output
//            on every cycle and a few literal checks pin that model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_sequencer;

   localparam int NDUT = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        req_valid [NDUT];
   logic        req_write [NDUT];
   logic [1:0]  req_len   [NDUT];
   logic [15:0] req_addr  [NDUT];
   logic        req_wrap  [NDUT];
   logic [23:0] req_wdata [NDUT];
   wire         req_ready [NDUT];
   wire         rsp_valid [NDUT];
   wire  [23:0] rsp_rdata [NDUT];
   wire  [15:0] mem_addr  [NDUT];
   wire         mem_rden  [NDUT];
   wire         mem_wren  [NDUT];
   wire  [7:0]  mem_wdata [NDUT];
   wire  [7:0]  mem_q     [NDUT];

   logic [7:0]  ram  [65536];
   logic [7:0]  pipe [NDUT][4];

   int cyc = 0;
   int n_checks = 0;
   int n_fail = 0;
   bit chk_en = 1'b0;

   function automatic int lat_of(input int d);
      return (d == 0) ? 2 : ((d == 1) ? 1 : 4);
   endfunction

   generate
      for (genvar i = 0; i < NDUT; i++) begin : g_dut
         localparam int L = (i == 0) ? 2 : ((i == 1) ? 1 : 4);
         mem_access_sequencer #(
            .ADDR_W(16), .DATA_W(8), .MAX_BYTES(3), .RD_LATENCY(L)
         ) u_dut (
            .i_clk          (clk),
            .i_reset        (rst),
            .i_req_valid    (req_valid[i]),
            .o_req_ready    (req_ready[i]),
            .i_req_write    (req_write[i]),
            .i_req_len      (req_len[i]),
            .i_req_addr     (req_addr[i]),
            .i_req_page_wrap(req_wrap[i]),
            .i_req_wdata    (req_wdata[i]),
            .o_rsp_valid    (rsp_valid[i]),
            .o_rsp_rdata    (rsp_rdata[i]),
            .o_mem_address  (mem_addr[i]),
            .o_mem_rden     (mem_rden[i]),
            .o_mem_wren     (mem_wren[i]),
            .o_mem_wdata    (mem_wdata[i]),
            .i_mem_q        (mem_q[i])
         );
         // RAM data for an address sampled at edge t appears after edge t+L-1.
         assign mem_q[i] = pipe[i][L-1];
      end
   endgenerate

   always @(posedge clk) begin
      cyc <= cyc + 1;
      for (int d = 0; d < NDUT; d++) begin
         if (mem_wren[d] === 1'b1) ram[mem_addr[d]] <= mem_wdata[d];
         pipe[d][0] <= ram[mem_addr[d]];
         for (int s = 1; s < 4; s++) pipe[d][s] <= pipe[d][s-1];
      end
   end

   // ---------------- behavioural model ----------------
   bit          m_act  [NDUT];
   int          m_e0   [NDUT];
   bit          m_wr   [NDUT];
   int          m_n    [NDUT];
   logic [15:0] m_a    [NDUT];
   bit          m_wrap [NDUT];
   logic [23:0] m_wd   [NDUT];
   logic [23:0] m_rdata[NDUT];

   function automatic logic [15:0] addr_of(input logic [15:0] a, input int j, input bit wrap);
      logic [15:0] r;
      if (wrap) r = {a[15:8], 8'(int'(a[7:0]) + j)};
      else      r = 16'(int'(a) + j);
      return r;
   endfunction

   function automatic int dur(input int lat, input bit wr, input int n);
      if (n == 0) return 1;
      if (wr)     return n + 1;
      return n * (lat + 1) + 1;
   endfunction

   task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s dut%0d cycle %0d: actual 0x%0h required 0x%0h", nm, d, cyc, act, exp);
      end
   endtask

   task automatic start_model(input int d, input bit wr, input int n, input logic [15:0] a,
                              input bit wrap, input logic [23:0] wd);
      logic [23:0] r;
      r = '0;
      if (!wr) for (int j = 0; j < n; j++) r[8*j +: 8] = ram[addr_of(a, j, wrap)];
      m_wr[d] = wr; m_n[d] = n; m_a[d] = a; m_wrap[d] = wrap; m_wd[d] = wd;
      m_e0[d] = cyc; m_act[d] = 1'b1; m_rdata[d] = r;
   endtask

   // ---------------- per-cycle compare ----------------
   int          c_k, c_D, c_P, c_lat;
   bit          c_idle, e_ready, e_rv, e_rden, e_wren;
   logic [15:0] e_addr;
   logic [7:0]  e_wd;

   always @(negedge clk) begin
      if (chk_en) begin
         for (int d = 0; d < NDUT; d++) begin
            c_lat = lat_of(d);
            c_k = m_act[d] ? (cyc - m_e0[d] + 1) : 0;
            c_D = dur(c_lat, m_wr[d], m_n[d]);
            c_idle = 1'b1; e_ready = 1'b1; e_rv = 1'b0; e_rden = 1'b0; e_wren = 1'b0;
            e_addr = '0; e_wd = '0;
            if (m_act[d] && c_k >= 1 && c_k <= c_D) begin
               c_idle = 1'b0; e_ready = 1'b0;
               if (c_k == c_D) begin
                  e_rv = 1'b1;
               end else if (m_wr[d]) begin
                  e_wren = 1'b1;
                  e_addr = addr_of(m_a[d], c_k - 1, m_wrap[d]);
                  e_wd   = m_wd[d][8*(c_k-1) +: 8];
               end else begin
                  c_P    = c_lat + 1;
                  e_rden = ((c_k - 1) % c_P) < c_lat;
                  e_addr = addr_of(m_a[d], (c_k - 1) / c_P, m_wrap[d]);
               end
            end
            chk("req_ready", d, 32'(req_ready[d]), 32'(e_ready));
            chk("rsp_valid", d, 32'(rsp_valid[d]), 32'(e_rv));
            chk("mem_rden",  d, 32'(mem_rden[d]),  32'(e_rden));
            chk("mem_wren",  d, 32'(mem_wren[d]),  32'(e_wren));
            if (c_idle || e_rden || e_wren) chk("mem_address", d, 32'(mem_addr[d]), 32'(e_addr));
            if (c_idle || e_wren)           chk("mem_wdata",   d, 32'(mem_wdata[d]), 32'(e_wd));
            if (c_idle || e_rv)             chk("rsp_rdata",   d, 32'(rsp_rdata[d]), 32'(m_rdata[d]));
         end
      end
   end

   // ---------------- stimulus ----------------
   logic [15:0] q_addr[$];
   logic [7:0]  q_wd[$];
   int          done_k;
   logic [23:0] done_rd;

   function automatic logic [31:0] qa(input int i);
      return (q_addr.size() > i) ? 32'(q_addr[i]) : 32'hFFFF_FFFF;
   endfunction

   function automatic logic [31:0] qw(input int i);
      return (q_wd.size() > i) ? 32'(q_wd[i]) : 32'hFFFF_FFFF;
   endfunction

   task automatic idle_cycles(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   // Entered and left at posedge+1 of an idle cycle.
   task automatic run_req(input int d, input bit wr, input logic [1:0] len, input logic [15:0] a,
                          input bit wrap, input logic [23:0] wd, input bit junk);
      int n, D;
      n = (int'(len) > 3) ? 3 : int'(len);
      q_addr.delete(); q_wd.delete(); done_k = -1; done_rd = '0;
      req_valid[d] = 1'b1; req_write[d] = wr; req_len[d] = len;
      req_addr[d] = a; req_wrap[d] = wrap; req_wdata[d] = wd;
      @(posedge clk); #1;
      start_model(d, wr, n, a, wrap, wd);
      D = dur(lat_of(d), wr, n);
      for (int k = 1; k <= D; k++) begin
         if (junk) begin
            req_valid[d] = 1'b1;         req_write[d] = 1'($urandom);
            req_len[d]   = 2'($urandom); req_addr[d]  = 16'($urandom);
            req_wrap[d]  = 1'($urandom); req_wdata[d] = 24'($urandom);
         end else begin
            req_valid[d] = 1'b0;
         end
         if (rsp_valid[d] === 1'b1 && done_k < 0) begin done_k = k; done_rd = rsp_rdata[d]; end
         if (mem_rden[d] === 1'b1 || mem_wren[d] === 1'b1) begin
            if (q_addr.size() == 0 || q_addr[$] != mem_addr[d]) q_addr.push_back(mem_addr[d]);
         end
         if (mem_wren[d] === 1'b1) q_wd.push_back(mem_wdata[d]);
         @(posedge clk); #1;
      end
      req_valid[d] = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [15:0] ra;
      rst = 1'b1;
      for (int d = 0; d < NDUT; d++) begin
         req_valid[d] = 1'b0; req_write[d] = 1'b0; req_len[d] = '0;
         req_addr[d] = '0; req_wrap[d] = 1'b0; req_wdata[d] = '0;
         m_act[d] = 1'b0; m_e0[d] = 0; m_wr[d] = 1'b0; m_n[d] = 0;
         m_a[d] = '0; m_wrap[d] = 1'b0; m_wd[d] = '0; m_rdata[d] = '0;
      end
      for (int i = 0; i < 65536; i++) ram[i] <= 8'($urandom);
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      chk_en = 1'b1;
      chk("reset_ready", 0, 32'(req_ready[0]), 32'd1);
      chk("reset_rdata", 0, 32'(rsp_rdata[0]), 32'd0);
      idle_cycles(1);

      // Read len=1 at 0x1000 holding 0xA9.
      ram[16'h1000] <= 8'hA9;
      run_req(0, 1'b0, 2'd1, 16'h1000, 1'b0, 24'h0, 1'b0);
      chk("rd1_done_cycle", 0, 32'(done_k), 32'd4);
      chk("rd1_rdata", 0, 32'(done_rd), 32'h0000A9);
      chk("rd1_addr0", 0, qa(0), 32'h1000);

      // Read len=3 at 0x1000 holding 4C 34 12.
      ram[16'h1000] <= 8'h4C; ram[16'h1001] <= 8'h34; ram[16'h1002] <= 8'h12;
      run_req(0, 1'b0, 2'd3, 16'h1000, 1'b0, 24'h0, 1'b1);
      chk("rd3_done_cycle", 0, 32'(done_k), 32'd10);
      chk("rd3_rdata", 0, 32'(done_rd), 32'h12344C);
      chk("rd3_addr2", 0, qa(2), 32'h1002);

      // Page wrap on and off across 0x00FF.
      run_req(0, 1'b0, 2'd2, 16'h00FF, 1'b1, 24'h0, 1'b1);
      chk("wrap1_addr0", 0, qa(0), 32'h00FF);
      chk("wrap1_addr1", 0, qa(1), 32'h0000);
      run_req(0, 1'b0, 2'd2, 16'h00FF, 1'b0, 24'h0, 1'b0);
      chk("wrap0_addr1", 0, qa(1), 32'h0100);

      // Write len=2 at 0xFFFF.
      run_req(0, 1'b1, 2'd2, 16'hFFFF, 1'b0, 24'h0055AA, 1'b1);
      chk("wr_addr0", 0, qa(0), 32'hFFFF);
      chk("wr_addr1", 0, qa(1), 32'h0000);
      chk("wr_data0", 0, qw(0), 32'hAA);
      chk("wr_data1", 0, qw(1), 32'h55);
      chk("wr_done_cycle", 0, 32'(done_k), 32'd3);
      chk("wr_rdata", 0, 32'(done_rd), 32'd0);
      chk("wr_ram_ffff", 0, 32'(ram[16'hFFFF]), 32'hAA);

      // Latency 1 and latency 4 builds, len=2 reads.
      run_req(1, 1'b0, 2'd2, 16'h2222, 1'b0, 24'h0, 1'b1);
      chk("lat1_done_cycle", 1, 32'(done_k), 32'd5);
      run_req(2, 1'b0, 2'd2, 16'h3333, 1'b0, 24'h0, 1'b1);
      chk("lat4_done_cycle", 2, 32'(done_k), 32'd11);

      // Reset during RD_WAIT of a len=3 read.
      req_valid[0] = 1'b1; req_write[0] = 1'b0; req_len[0] = 2'd3;
      req_addr[0] = 16'h2000; req_wrap[0] = 1'b0; req_wdata[0] = '0;
      @(posedge clk); #1;
      start_model(0, 1'b0, 3, 16'h2000, 1'b0, 24'h0);
      req_valid[0] = 1'b0;
      @(posedge clk); #1;
      chk("rw_rden_before_reset", 0, 32'(mem_rden[0]), 32'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      for (int d = 0; d < NDUT; d++) begin m_act[d] = 1'b0; m_rdata[d] = '0; end
      chk("post_reset_ready", 0, 32'(req_ready[0]), 32'd1);
      chk("post_reset_rden", 0, 32'(mem_rden[0]), 32'd0);
      chk("post_reset_addr", 0, 32'(mem_addr[0]), 32'd0);
      idle_cycles(3);
      run_req(0, 1'b0, 2'd0, 16'h1234, 1'b0, 24'h0, 1'b0);
      chk("len0_done_cycle", 0, 32'(done_k), 32'd1);
      chk("len0_no_mem", 0, 32'(q_addr.size()), 32'd0);

      // Randomized requests, biased toward address boundaries.
      for (int d = 0; d < NDUT; d++) begin
         for (int it = 0; it < 25; it++) begin
            case ($urandom_range(0, 3))
               0:       ra = 16'hFFFF - 16'($urandom_range(0, 2));
               1:       ra = {8'($urandom), 8'hFD + 8'($urandom_range(0, 2))};
               default: ra = 16'($urandom);
            endcase
            run_req(d, 1'($urandom), 2'($urandom_range(0, 3)), ra, 1'($urandom),
                    24'($urandom), 1'($urandom));
            idle_cycles($urandom_range(0, 2));
         end
      end
      idle_cycles(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
